// File: rtl/cmp_pkg.sv
// Shared fetch/decode definitions: datapath widths, the NOP encoding and the
// fetch packet carried from fetch into decode.
package cmp_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

  function automatic fetch_pkt_t make_pkt(input logic [PC_W-1:0] pc,
                                          input logic [INSTR_W-1:0] instr);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

endpackage

// File: rtl/fetch_decode_buf.sv
// Two-entry elastic buffer between fetch and decode: absorbs decode stalls,
// refuses pushes when full (flagging ovf_err) and empties on a redirect flush.
module fetch_decode_buf #(
  parameter int PC_W    = cmp_pkg::PC_W,
  parameter int INSTR_W = cmp_pkg::INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enableBuf,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               ovf_err,
  output logic [1:0]         count
);

  import cmp_pkg::*;

  logic [PC_W-1:0]    pc_mem    [2];
  logic [INSTR_W-1:0] instr_mem [2];

  logic       wr_ptr_reg, wr_ptr_next;
  logic       rd_ptr_reg, rd_ptr_next;
  logic [1:0] count_reg,  count_next;
  logic       ovf_reg,    ovf_next;
  logic       full;
  logic       push;
  logic       pop;

  assign full      = (count_reg == 2'(DEPTH));
  assign in_ready  = ~full;
  assign out_valid = (count_reg != 2'd0);
  assign push      = enableBuf & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    // A refused push from fetch is the overflow event; a flush makes the word moot.
    ovf_next    = ovf_reg | (enableBuf & full & ~flush);
    if (flush) begin
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
      count_next  = 2'd0;
    end else begin
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      if (push && !pop)      count_next = count_reg + 2'd1;
      else if (pop && !push) count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pc_mem[gi]    <= '0;
          instr_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          pc_mem[gi]    <= in_pc;
          instr_mem[gi] <= in_instr;
        end
      end
    end
  endgenerate

  // Stale storage is masked so decode only ever sees a NOP when nothing is valid.
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : INSTR_W'(NOP_INSTR);
  assign ovf_err   = ovf_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Bench for fetch_decode_buf: constant vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_fetch_decode_buf;
  import cmp_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               enableBuf;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               ovf_err;
  logic [1:0]         count;

  int checks = 0;
  int errors = 0;

  fetch_pkt_t model_q[$];
  logic       model_ovf;

  always #5 clk = ~clk;

  fetch_decode_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .enableBuf(enableBuf), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .ovf_err(ovf_err), .count(count)
  );

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fl;
    logic        rdy;
    logic [1:0]  e_cnt;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_inr;
    logic        e_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_cnt, input logic e_val,
                           input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_inr, input logic e_ovf);
    check({tag, ".count"},     64'(count),     64'(e_cnt));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_val));
    check({tag, ".out_pc"},    64'(out_pc),    64'(e_pc));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(e_instr));
    check({tag, ".in_ready"},  64'(in_ready),  64'(e_inr));
    check({tag, ".ovf_err"},   64'(ovf_err),   64'(e_ovf));
    $display("txn %-10s cnt=%0d val=%0b pc=%0h instr=%0h rdy_in=%0b ovf=%0b",
             tag, count, out_valid, out_pc, out_instr, in_ready, ovf_err);
  endtask

  // Reference: buffer is a FIFO of at most two packets; flush empties it outright.
  task automatic model_edge();
    bit full;
    full = (model_q.size() == 2);
    if (flush) begin
      model_q.delete();
    end else begin
      if (enableBuf && full) model_ovf = 1'b1;
      if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
      if (enableBuf && !full) model_q.push_back(make_pkt(in_pc, in_instr));
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_pc, e_instr;
    e_pc    = (model_q.size() > 0) ? model_q[0].pc    : 32'h0;
    e_instr = (model_q.size() > 0) ? model_q[0].instr : NOP_INSTR;
    check_all(tag, 2'(model_q.size()), model_q.size() > 0, e_pc, e_instr,
              model_q.size() != 2, model_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic rdy);
    enableBuf = en; in_pc = pc; in_instr = instr; flush = fl; out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;

    // Reset state
    do_reset();
    check_all("reset", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, overflow, drain, idle-on-empty
    vecs[0] = '{1, 32'd1, 32'hA5, 0, 0, 2'd1, 1, 32'd1, 32'hA5, 1, 0};
    vecs[1] = '{1, 32'd2, 32'hB6, 0, 0, 2'd2, 1, 32'd1, 32'hA5, 0, 0};
    vecs[2] = '{1, 32'd3, 32'hC7, 0, 0, 2'd2, 1, 32'd1, 32'hA5, 0, 1};
    vecs[3] = '{0, 32'd0, 32'h00, 0, 1, 2'd1, 1, 32'd2, 32'hB6, 1, 1};
    vecs[4] = '{0, 32'd0, 32'h00, 0, 1, 2'd0, 0, 32'd0, 32'h00, 1, 1};
    vecs[5] = '{0, 32'd0, 32'h00, 0, 1, 2'd0, 0, 32'd0, 32'h00, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].en, vecs[i].pc, vecs[i].instr, vecs[i].fl, vecs[i].rdy);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_val, vecs[i].e_pc,
                vecs[i].e_instr, vecs[i].e_inr, vecs[i].e_ovf);
    end

    // Full + pop: in_ready rises after the pop, no same-cycle refill
    do_reset();
    drive(1, 32'h60, 32'h600, 0, 0); step();
    drive(1, 32'h61, 32'h601, 0, 0); step();
    drive(1, 32'h62, 32'h602, 0, 1); step();
    check_all("fullpop", 2'd1, 1'b1, 32'h61, 32'h601, 1'b1, 1'b1);

    // Streaming: count holds 1, head tracks the newest word
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'(10 + k), 32'(16'hE000 + k), 0, 1);
      step();
      check_all($sformatf("stream%0d", k), 2'd1, 1'b1, 32'(10 + k),
                32'(16'hE000 + k), 1'b1, 1'b0);
    end
    drive(0, 0, 0, 0, 1); step();
    check_all("streamend", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with an incoming wrong-path word
    do_reset();
    drive(1, 32'd31, 32'h31, 0, 0); step();
    drive(1, 32'd32, 32'h32, 0, 0); step();
    drive(1, 32'd33, 32'h33, 1, 1); step();
    check_all("flush", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1, 32'd40, 32'h40, 0, 0); step();
    check_all("postflush", 2'd1, 1'b1, 32'd40, 32'h40, 1'b1, 1'b0);

    // Asynchronous reset between edges
    do_reset();
    drive(1, 32'd45, 32'h45, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    check_all("asyncrst", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    drive(1, 32'd50, 32'h50, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check_all("afterrst", 2'd1, 1'b1, 32'd50, 32'h50, 1'b1, 1'b0);

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
